// File: rtl/mul_and_pkg.sv
// rtl/mul_and_pkg.sv - shared constants, stage records and helpers for the mul_and arbiter
package mul_and_pkg;

  localparam int WIDTH_DEFAULT = 16;
  localparam int N_REQ_DEFAULT = 4;
  localparam int TAG_W_DEFAULT = $clog2(N_REQ_DEFAULT);

  function automatic int tag_width(input int n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  // Stage 1 carries raw operands; later stages carry the partial/final result.
  typedef struct packed {
    logic                     valid;
    logic [TAG_W_DEFAULT-1:0] tag;
    logic [WIDTH_DEFAULT-1:0] a;
    logic [WIDTH_DEFAULT-1:0] b;
    logic [WIDTH_DEFAULT-1:0] c;
  } op_stage_t;

  typedef struct packed {
    logic                     valid;
    logic [TAG_W_DEFAULT-1:0] tag;
    logic [WIDTH_DEFAULT-1:0] res;
  } res_stage_t;

endpackage

// File: rtl/mul_and_pipe.sv
// rtl/mul_and_pipe.sv - LATENCY-stage (a*b)&c datapath with valid and tag sideband
module mul_and_pipe
  import mul_and_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int TAG_W   = TAG_W_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // With one stage the multiply-and lands directly in the only register;
  // otherwise stage 1 holds operands and the result stages follow.
  localparam int RES_N   = (LATENCY == 1) ? 1 : LATENCY - 1;
  localparam int RES_OFF = LATENCY - RES_N;

  logic [LATENCY-1:0] vld;
  logic [TAG_W-1:0]   tag [LATENCY];
  logic [WIDTH-1:0]   res [RES_N];

  logic               src_valid;
  logic [WIDTH-1:0]   src_a;
  logic [WIDTH-1:0]   src_b;
  logic [WIDTH-1:0]   src_c;
  logic [WIDTH-1:0]   prod;

  generate
    if (LATENCY == 1) begin : g_direct
      assign src_valid = in_valid;
      assign src_a     = in_a;
      assign src_b     = in_b;
      assign src_c     = in_c;
    end else begin : g_op_stage
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] c_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= '0;
        end else if (in_valid) begin
          a_q <= in_a;
          b_q <= in_b;
          c_q <= in_c;
        end
      end

      assign src_valid = vld[0];
      assign src_a     = a_q;
      assign src_b     = b_q;
      assign src_c     = c_q;
    end
  endgenerate

  // WIDTH-bit context keeps only the low half of the product.
  assign prod = src_a * src_b;

  // Result registers load only on a valid arrival, so the last stage holds
  // the most recent result between responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) tag[i] <= '0;
      for (int j = 0; j < RES_N; j++) res[j] <= '0;
    end else begin
      vld[0] <= in_valid;
      tag[0] <= in_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
      if (src_valid) res[0] <= prod & src_c;
      for (int j = 1; j < RES_N; j++) begin
        if (vld[j+RES_OFF-1]) res[j] <= res[j-1];
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_tag   = tag[LATENCY-1];
  assign out_data  = res[RES_N-1];
  assign busy      = |vld;

endmodule

// File: rtl/mul_and_arbiter.sv
// rtl/mul_and_arbiter.sv - round-robin front end sharing one (a*b)&c pipeline among N_REQ requesters
module mul_and_arbiter
  import mul_and_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  input  logic [N_REQ*WIDTH-1:0]   req_c,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     idle
);

  localparam int TAG_W = tag_width(N_REQ);

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] win;
  logic [TAG_W-1:0] idx;
  logic             found;
  logic             fire;

  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  // First requesting index found by a cyclic search starting at ptr.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = TAG_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign fire      = rst_n & en & found;
  assign req_ready = fire ? (N_REQ'(1) << win) : '0;
  assign grant_id  = win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (fire) begin
      ptr <= (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    end
  end

  mul_and_pipe #(
    .WIDTH   (WIDTH),
    .TAG_W   (TAG_W),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (fire),
    .in_tag    (win),
    .in_a      (req_a[win*WIDTH +: WIDTH]),
    .in_b      (req_b[win*WIDTH +: WIDTH]),
    .in_c      (req_c[win*WIDTH +: WIDTH]),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (rsp_data),
    .busy      (busy)
  );

  assign rsp_valid = out_valid ? (N_REQ'(1) << out_tag) : '0;
  assign idle      = ~(busy | fire);

endmodule

// File: tb/tb_mul_and_arbiter.sv
// tb/tb_mul_and_arbiter.sv - self-checking bench for mul_and_arbiter
module tb_mul_and_arbiter;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_c;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [1:0]     grant_id;
  logic           idle;

  always #5 clk = ~clk;

  mul_and_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .grant_id  (grant_id),
    .idle      (idle)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    int           due;
    int           tag;
    logic [W-1:0] data;
  } pend_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] exp;
  } vec_t;

  pend_t        pend[$];
  int           cyc = 0;
  int           m_ptr = 0;
  int           m_win = 0;
  bit           m_fire = 0;
  logic [W-1:0] m_last = '0;

  logic [N-1:0] obs_ready;
  logic [N-1:0] obs_valid;
  logic [W-1:0] obs_data;
  logic [1:0]   obs_gid;
  logic         obs_idle;
  int           rsp_tags[$];
  logic [W-1:0] rsp_datas[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
    longint p;
    p = (longint'(a) * longint'(b)) % (longint'(1) << W);
    return W'(p) & c;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_rd;
    int           i;
    m_fire = 0;
    m_win  = 0;
    if (rst_n && en) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!m_fire && req_valid[i]) begin
          m_fire = 1;
          m_win  = i;
        end
      end
    end
    exp_ready = m_fire ? (N'(1) << m_win) : '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv = N'(1) << pend[0].tag;
      exp_rd = pend[0].data;
    end else begin
      exp_rv = '0;
      exp_rd = m_last;
    end
    chk("req_ready", req_ready, exp_ready);
    if (m_fire) chk("grant_id", grant_id, m_win);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", rsp_data, exp_rd);
    chk("idle", idle, (pend.size() == 0 && !m_fire));
    obs_ready = req_ready;
    obs_valid = rsp_valid;
    obs_data  = rsp_data;
    obs_gid   = grant_id;
    obs_idle  = idle;
    for (int t = 0; t < N; t++) begin
      if (rsp_valid[t]) begin
        rsp_tags.push_back(t);
        rsp_datas.push_back(rsp_data);
      end
    end
  endtask

  task automatic update_model();
    if (pend.size() > 0 && pend[0].due == cyc) begin
      m_last = pend[0].data;
      void'(pend.pop_front());
    end
    if (!rst_n) begin
      pend.delete();
      m_ptr  = 0;
      m_last = '0;
    end else if (m_fire) begin
      pend.push_back('{cyc + LAT, m_win,
        ref_op(req_a[m_win*W +: W], req_b[m_win*W +: W], req_c[m_win*W +: W])});
      m_ptr = (m_win + 1) % N;
    end
    cyc++;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_req(int r, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
    req_valid    = '0;
    req_valid[r] = 1'b1;
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_c[r*W +: W] = c;
  endtask

  vec_t         vecs[8];
  int           gids[$];
  int           n_acc;
  logic [W-1:0] stream_exp[5];
  logic [W-1:0] sa, sb, sc;

  initial begin
    vecs[0] = '{16'h0003, 16'h0005, 16'hFFFF, 16'h000F};
    vecs[1] = '{16'h0100, 16'h0100, 16'hFFFF, 16'h0000};
    vecs[2] = '{16'h00FF, 16'h0101, 16'h0F0F, 16'h0F0F};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0001};
    vecs[4] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0000};
    vecs[5] = '{16'h0003, 16'h0005, 16'h0000, 16'h0000};
    vecs[6] = '{16'h8000, 16'h0002, 16'hFFFF, 16'h0000};
    vecs[7] = '{16'h00FF, 16'h0100, 16'hFF00, 16'hFF00};

    // Reset with every requester asking and en high: no grant may leak.
    rst_n = 1'b0;
    en = 1'b1;
    req_valid = '1;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_c = {$urandom, $urandom};
    @(posedge clk);
    #1;
    step();
    chk("reset_ready", obs_ready, 0);
    chk("reset_idle", obs_idle, 1);
    chk("reset_rsp_data", obs_data, 0);
    rst_n = 1'b1;

    // Fairness from ptr=0 with all four requesting.
    rsp_tags.delete();
    gids.delete();
    for (int k = 0; k < 8; k++) begin
      step();
      if (obs_ready != 0) gids.push_back(obs_gid);
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) step();
    chk("fair_grants", gids.size(), 8);
    chk("fair_rsps", rsp_tags.size(), 8);
    for (int k = 0; k < 8 && k < gids.size() && k < rsp_tags.size(); k++) begin
      chk("fair_grant_order", gids[k], k % 4);
      chk("fair_rsp_order", rsp_tags[k], k % 4);
    end

    // Arithmetic vectors, single request each, checked at T+2.
    for (int k = 0; k < 8; k++) begin
      set_req((k + 1) % N, vecs[k].a, vecs[k].b, vecs[k].c);
      step();
      req_valid = '0;
      step();
      step();
      chk("vec_valid", obs_valid, N'(1) << ((k + 1) % N));
      chk("vec_data", obs_data, vecs[k].exp);
      step();
      chk("vec_idle_after", obs_idle, 1);
    end

    // Enable gating after two back-to-back accepts.
    rsp_tags.delete();
    req_valid = 4'b0011;
    step();
    chk("en_acc0", obs_ready != 0, 1);
    step();
    chk("en_acc1", obs_ready != 0, 1);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("en_no_ready", obs_ready, 0);
    end
    chk("en_rsp_count", rsp_tags.size(), 2);
    chk("en_idle", obs_idle, 1);
    en = 1'b1;
    req_valid = '0;

    // Reset one cycle after an accept.
    set_req(3, 16'h0007, 16'h0009, 16'hFFFF);
    step();
    req_valid = '0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = '1;
    rsp_tags.delete();
    step();
    chk("rst_first_grant", obs_gid, 0);
    chk("rst_no_late", obs_valid, 0);
    step();
    req_valid = '0;
    for (int k = 0; k < 3; k++) step();
    chk("rst_rsp_count", rsp_tags.size(), 2);
    foreach (rsp_tags[k]) chk("rst_rsp_tag", rsp_tags[k], k);

    // Lone requester 2 streaming distinct operands.
    rsp_tags.delete();
    rsp_datas.delete();
    n_acc = 0;
    for (int k = 0; k < 5; k++) begin
      sa = W'(16'h0101 * (k + 1) + 3);
      sb = W'(16'h0033 + 7 * k);
      sc = W'(16'hF0F0 >> k);
      stream_exp[k] = ref_op(sa, sb, sc);
      set_req(2, sa, sb, sc);
      step();
      if (obs_ready == 4'b0100) n_acc++;
    end
    req_valid = '0;
    for (int k = 0; k < 3; k++) step();
    chk("stream_accepts", n_acc, 5);
    chk("stream_rsps", rsp_tags.size(), 5);
    for (int k = 0; k < 5 && k < rsp_tags.size(); k++) begin
      chk("stream_tag", rsp_tags[k], 2);
      chk("stream_data", rsp_datas[k], stream_exp[k]);
    end

    // Randomized traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      rst_n     = ($urandom % 60) != 0;
      en        = ($urandom % 8) != 0;
      req_valid = N'($urandom);
      req_a     = {$urandom, $urandom};
      req_b     = {$urandom, $urandom};
      req_c     = {$urandom, $urandom};
      step();
    end
    rst_n = 1'b1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) step();
    chk("final_idle", obs_idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
